// File: rtl/rgb_pkg.sv
// Shared definitions for the WS2812b transmit path: word bit positions,
// default 96 MHz timing constants and the transmitter state encoding.
package rgb_pkg;

    // Word layout produced by the serial-bit-to-word capture stage
    localparam int BNUM_VALID        = 31;
    localparam int BNUM_STREAM_RESET = 30;
    localparam int BNUM_FIRST_DATA   = 23;
    localparam int BNUM_LAST_DATA    = 0;

    // Default WS2812b timing in 96 MHz clock cycles
    localparam int DEF_T0H_CLKS    = 38;    // 0.4 us
    localparam int DEF_T1H_CLKS    = 77;    // 0.8 us
    localparam int DEF_TBIT_CLKS   = 120;   // 1.25 us
    localparam int DEF_TRESET_CLKS = 4800;  // 50 us
    localparam int DEF_GAP_CLKS    = 480;   // 5 us
    localparam int DEF_CNT_W       = 13;

    // Transmitter state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_RST  = 2'd3
    } state_t;

endpackage

// File: rtl/rgb_sout_bitgen.sv
// Single-bit WS2812b waveform generator. A start strobe latches one data
// bit and emits its HIGH then LOW phase; done is high on the last LOW clk
// so the caller can chain the next bit with no gap.
module rgb_sout_bitgen
    import rgb_pkg::*;
#(
    parameter int T0H_CLKS  = DEF_T0H_CLKS,
    parameter int T1H_CLKS  = DEF_T1H_CLKS,
    parameter int TBIT_CLKS = DEF_TBIT_CLKS,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   start,
    input  logic   bit_val,
    output logic   sdata,
    output state_t phase,
    output logic   done
);

    localparam logic [CNT_W-1:0] T0H_LD = CNT_W'(T0H_CLKS - 1);
    localparam logic [CNT_W-1:0] T1H_LD = CNT_W'(T1H_CLKS - 1);
    localparam logic [CNT_W-1:0] T0L_LD = CNT_W'(TBIT_CLKS - T0H_CLKS - 1);
    localparam logic [CNT_W-1:0] T1L_LD = CNT_W'(TBIT_CLKS - T1H_CLKS - 1);
    localparam logic [CNT_W-1:0] ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    state_t           phase_r;
    logic [CNT_W-1:0] timer_r;
    logic             bit_r;
    logic             sdata_r;

    // Phase sequencer: HIGH for the bit's high time, LOW for the remainder
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_r <= ST_IDLE;
            timer_r <= ZERO;
            bit_r   <= 1'b0;
            sdata_r <= 1'b0;
        end else begin
            case (phase_r)
                ST_HIGH: begin
                    if (timer_r == ZERO) begin
                        phase_r <= ST_LOW;
                        sdata_r <= 1'b0;
                        timer_r <= bit_r ? T1L_LD : T0L_LD;
                    end else begin
                        timer_r <= timer_r - ONE;
                    end
                end
                ST_LOW: begin
                    if (timer_r == ZERO) begin
                        if (start) begin
                            phase_r <= ST_HIGH;
                            sdata_r <= 1'b1;
                            bit_r   <= bit_val;
                            timer_r <= bit_val ? T1H_LD : T0H_LD;
                        end else begin
                            phase_r <= ST_IDLE;
                        end
                    end else begin
                        timer_r <= timer_r - ONE;
                    end
                end
                ST_IDLE: begin
                    if (start) begin
                        phase_r <= ST_HIGH;
                        sdata_r <= 1'b1;
                        bit_r   <= bit_val;
                        timer_r <= bit_val ? T1H_LD : T0H_LD;
                    end else begin
                        sdata_r <= 1'b0;
                    end
                end
                default: begin
                    phase_r <= ST_IDLE;
                    sdata_r <= 1'b0;
                    timer_r <= ZERO;
                end
            endcase
        end
    end

    assign sdata = sdata_r;
    assign phase = phase_r;
    assign done  = (phase_r == ST_LOW) && (timer_r == ZERO);

endmodule

// File: rtl/rgb_wrd2sout.sv
// WS2812b transmitter: pops Status/G/R/B words from a first-word-fall-through
// FIFO and drives the single-wire serial output. Owns FIFO pops, the data
// shift register and the stream-reset (RST) low period; the per-bit waveform
// comes from rgb_sout_bitgen.
// Optional build macro RGB_WRD2SOUT_GAP_RESET_EN: after a data word, if the
// FIFO stays empty for GAP_CLKS clks in IDLE, flag out_underflow (sticky) and
// emit a stream reset automatically.
module rgb_wrd2sout
    import rgb_pkg::*;
#(
    parameter int T0H_CLKS    = DEF_T0H_CLKS,
    parameter int T1H_CLKS    = DEF_T1H_CLKS,
    parameter int TBIT_CLKS   = DEF_TBIT_CLKS,
    parameter int TRESET_CLKS = DEF_TRESET_CLKS,
    parameter int CNT_W       = DEF_CNT_W
`ifdef RGB_WRD2SOUT_GAP_RESET_EN
    ,
    parameter int GAP_CLKS    = DEF_GAP_CLKS
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_word,
    input  logic        in_rd_fifo_empty,
    output logic        out_rd_fifo_strobe,
    output logic        out_sdata,
    output logic        out_busy,
    output logic        out_underflow
);

    localparam logic [CNT_W-1:0] TRESET_LD = CNT_W'(TRESET_CLKS - 1);
    localparam logic [CNT_W-1:0] ZERO      = CNT_W'(0);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    // Remaining data bits after the one in flight; bit 23 goes straight to the bitgen
    logic [BNUM_FIRST_DATA-1:0] data_r;
    logic [4:0]                 idx_r;
    logic                       rst_act_r;
    logic [CNT_W-1:0]           rtimer_r;
    logic                       pop_q_r;

    state_t state_s;
    state_t bg_phase_s;
    logic   bg_done_s;
    logic   bg_sdata_s;
    logic   idle_s;
    logic   last_s;
    logic   pop_s;
    logic   is_data_word_s;
    logic   start_s;
    logic   bit_s;
    logic   unused_s;

`ifdef RGB_WRD2SOUT_GAP_RESET_EN
    localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_CLKS - 1);
    logic [CNT_W-1:0] gap_cnt_r;
    logic             gap_armed_r;
    logic             underflow_r;
`endif

    // Status bits 29..24 carry nothing for the transmitter
    assign unused_s = ^in_word[29:24];

    // Pop and bit-dispatch decisions for the current clk
    always_comb begin
        state_s        = rst_act_r ? ST_RST : bg_phase_s;
        idle_s         = (state_s == ST_IDLE);
        last_s         = bg_done_s && (idx_r == 5'd0);
        is_data_word_s = in_word[BNUM_VALID] && !in_word[BNUM_STREAM_RESET];
        // pop_q_r keeps a discarded word from being followed by a back-to-back pop
        if (rst_n && !in_rd_fifo_empty && !pop_q_r && (idle_s || last_s)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if (pop_s && is_data_word_s) begin
            start_s = 1'b1;
            bit_s   = in_word[BNUM_FIRST_DATA];
        end else if (bg_done_s && (idx_r != 5'd0)) begin
            start_s = 1'b1;
            bit_s   = data_r[BNUM_FIRST_DATA-1];
        end else begin
            start_s = 1'b0;
            bit_s   = 1'b0;
        end
    end

    // Word capture, bit index, stream-reset timer and optional gap watchdog
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_r    <= '0;
            idx_r     <= 5'd23;
            rst_act_r <= 1'b0;
            rtimer_r  <= ZERO;
            pop_q_r   <= 1'b0;
`ifdef RGB_WRD2SOUT_GAP_RESET_EN
            gap_cnt_r   <= ZERO;
            gap_armed_r <= 1'b0;
            underflow_r <= 1'b0;
`endif
        end else begin
            pop_q_r <= pop_s;
            if (pop_s) begin
                if (in_word[BNUM_STREAM_RESET]) begin
                    rst_act_r <= 1'b1;
                    rtimer_r  <= TRESET_LD;
                end else if (in_word[BNUM_VALID]) begin
                    data_r <= in_word[BNUM_FIRST_DATA-1:BNUM_LAST_DATA];
                    idx_r  <= 5'd23;
                end else begin
                    idx_r <= idx_r;
                end
            end else if (rst_act_r) begin
                if (rtimer_r == ZERO) begin
                    rst_act_r <= 1'b0;
                end else begin
                    rtimer_r <= rtimer_r - ONE;
                end
            end else if (bg_done_s && (idx_r != 5'd0)) begin
                idx_r  <= idx_r - 5'd1;
                data_r <= {data_r[BNUM_FIRST_DATA-2:0], 1'b0};
            end else begin
                idx_r <= idx_r;
            end
`ifdef RGB_WRD2SOUT_GAP_RESET_EN
            if (pop_s) begin
                gap_cnt_r <= ZERO;
                if (in_word[BNUM_STREAM_RESET]) begin
                    gap_armed_r <= 1'b0;
                end else if (in_word[BNUM_VALID]) begin
                    gap_armed_r <= 1'b1;
                end else begin
                    gap_armed_r <= gap_armed_r;
                end
            end else if (idle_s && in_rd_fifo_empty && gap_armed_r) begin
                if (gap_cnt_r == GAP_LD) begin
                    underflow_r <= 1'b1;
                    rst_act_r   <= 1'b1;
                    rtimer_r    <= TRESET_LD;
                    gap_armed_r <= 1'b0;
                    gap_cnt_r   <= ZERO;
                end else begin
                    gap_cnt_r <= gap_cnt_r + ONE;
                end
            end else begin
                gap_cnt_r <= ZERO;
            end
`endif
        end
    end

    rgb_sout_bitgen #(
        .T0H_CLKS  (T0H_CLKS),
        .T1H_CLKS  (T1H_CLKS),
        .TBIT_CLKS (TBIT_CLKS),
        .CNT_W     (CNT_W)
    ) u_bitgen (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_s),
        .bit_val (bit_s),
        .sdata   (bg_sdata_s),
        .phase   (bg_phase_s),
        .done    (bg_done_s)
    );

    assign out_rd_fifo_strobe = pop_s;
    assign out_sdata          = bg_sdata_s;
    assign out_busy           = (state_s != ST_IDLE);
`ifdef RGB_WRD2SOUT_GAP_RESET_EN
    assign out_underflow      = underflow_r;
`else
    assign out_underflow      = 1'b0;
`endif

endmodule
